// File: rtl/pipe_cu_pkg.sv
// Shared definitions for pipe_control_unit: opcode constants, control encodings, FSM states, ctrl bundle.
// The TRAP state exists only when PIPE_CU_TRAP_EN is defined.
package pipe_cu_pkg;

  localparam logic [4:0] OPCODE_LOAD   = 5'b00000;
  localparam logic [4:0] OPCODE_FENCE  = 5'b00011;
  localparam logic [4:0] OPCODE_OPIMM  = 5'b00100;
  localparam logic [4:0] OPCODE_AUIPC  = 5'b00101;
  localparam logic [4:0] OPCODE_STORE  = 5'b01000;
  localparam logic [4:0] OPCODE_OP     = 5'b01100;
  localparam logic [4:0] OPCODE_LUI    = 5'b01101;
  localparam logic [4:0] OPCODE_BRANCH = 5'b11000;
  localparam logic [4:0] OPCODE_JALR   = 5'b11001;
  localparam logic [4:0] OPCODE_JAL    = 5'b11011;
  localparam logic [4:0] OPCODE_SYSTEM = 5'b11100;

  localparam logic [2:0] ALUOP_ADD    = 3'b000;
  localparam logic [2:0] ALUOP_BRANCH = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE  = 3'b010;
  localparam logic [2:0] ALUOP_ITYPE  = 3'b011;
  localparam logic [2:0] ALUOP_UPPER  = 3'b100;
  localparam logic [2:0] ALUOP_JUMP   = 3'b101;

  localparam logic [1:0] REGWSRC_ALU   = 2'b00;
  localparam logic [1:0] REGWSRC_PC4   = 2'b01;
  localparam logic [1:0] REGWSRC_AUIPC = 2'b10;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_TARGET = 2'b01;
  localparam logic [1:0] PCSRC_JALR   = 2'b10;
  localparam logic [1:0] PCSRC_TRAP   = 2'b11;

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_STALL = 3'd1,
    ST_FLUSH = 3'd2,
`ifdef PIPE_CU_TRAP_EN
    ST_TRAP  = 3'd4,
`endif
    ST_HALT  = 3'd3
  } state_t;

  typedef struct packed {
    logic       branch;
    logic       memread;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic       jump;
    logic [2:0] aluop;
    logic [1:0] regwsrc;
    logic [1:0] pcsrc;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  function automatic logic load_use(input logic valid, input logic memread, input logic [4:0] rd,
                                    input logic [4:0] rs1, input logic [4:0] rs2);
    return valid && memread && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/pipe_cu_decode.sv
// Combinational opcode[6:2] -> datapath control bundle; unknown opcodes (incl. SYSTEM, FENCE) give all zeros.
module pipe_cu_decode
  import pipe_cu_pkg::*;
(
  input  logic [4:0]        opcode,
  output logic [CTRL_W-1:0] ctrl
);

  ctrl_t c;

  always_comb begin
    c = '0;
    case (opcode)
      OPCODE_OP: begin
        c.regwrite = 1'b1;
        c.aluop    = ALUOP_RTYPE;
      end
      OPCODE_LOAD: begin
        c.memread  = 1'b1;
        c.memtoreg = 1'b1;
        c.alusrc   = 1'b1;
        c.regwrite = 1'b1;
        c.aluop    = ALUOP_ADD;
      end
      OPCODE_STORE: begin
        c.memwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.aluop    = ALUOP_ADD;
      end
      OPCODE_BRANCH: begin
        c.branch = 1'b1;
        c.aluop  = ALUOP_BRANCH;
        c.pcsrc  = PCSRC_TARGET;
      end
      OPCODE_OPIMM: begin
        c.alusrc   = 1'b1;
        c.regwrite = 1'b1;
        c.aluop    = ALUOP_ITYPE;
      end
      OPCODE_LUI: begin
        c.alusrc   = 1'b1;
        c.regwrite = 1'b1;
        c.aluop    = ALUOP_UPPER;
      end
      OPCODE_AUIPC: begin
        c.alusrc   = 1'b1;
        c.regwrite = 1'b1;
        c.aluop    = ALUOP_UPPER;
        c.regwsrc  = REGWSRC_AUIPC;
      end
      OPCODE_JALR: begin
        c.alusrc   = 1'b1;
        c.regwrite = 1'b1;
        c.jump     = 1'b1;
        c.aluop    = ALUOP_JUMP;
        c.regwsrc  = REGWSRC_PC4;
        c.pcsrc    = PCSRC_JALR;
      end
      OPCODE_JAL: begin
        c.regwrite = 1'b1;
        c.jump     = 1'b1;
        c.aluop    = ALUOP_JUMP;
        c.regwsrc  = REGWSRC_PC4;
        c.pcsrc    = PCSRC_TARGET;
      end
      default: c = '0;
    endcase
  end

  assign ctrl = c;

endmodule

// File: rtl/pipe_control_unit.sv
// Pipelined control unit: decode, ID/EX control register, stall/flush/halt sequencing.
// Define PIPE_CU_TRAP_EN to turn ECALL/FENCE into a one-cycle trap redirect followed by a flush.
module pipe_control_unit
  import pipe_cu_pkg::*;
#(
  parameter int ALUOP_W     = 3,
  parameter int LOAD_STALL  = 1,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [4:0]         id_opcode,
  input  logic               id_inst20,
  input  logic [4:0]         id_rs1,
  input  logic [4:0]         id_rs2,
  input  logic [4:0]         ex_rd,
  input  logic               ex_memread,
  input  logic               redirect,
  output logic               pc_write,
  output logic               ifid_write,
  output logic               ifid_flush,
  output logic               ex_branch,
  output logic               ex_memread_o,
  output logic               ex_memtoreg,
  output logic               ex_memwrite,
  output logic               ex_alusrc,
  output logic               ex_regwrite,
  output logic               ex_jump,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic [1:0]         ex_regwsrc,
  output logic [1:0]         ex_pcsrc,
  output logic               halted,
  output logic               trap_req
);

  // The first stall/flush cycle happens in RUN, so the count holds the cycles still owed after it.
  localparam state_t     FLUSH_ENTRY = (FLUSH_DEPTH > 1) ? ST_FLUSH : ST_RUN;
  localparam state_t     STALL_ENTRY = (LOAD_STALL > 1) ? ST_STALL : ST_RUN;
  localparam logic [1:0] FLUSH_CNT   = 2'(FLUSH_DEPTH - 1);
  localparam logic [1:0] STALL_CNT   = 2'(LOAD_STALL - 1);

  state_t            state_reg, state_next;
  logic [1:0]        cnt_reg, cnt_next;
  ctrl_t             ex_reg, ex_next;
  logic [CTRL_W-1:0] dec_bits;
  ctrl_t             dec;
  logic              hazard;
  logic              is_ebreak;
`ifdef PIPE_CU_TRAP_EN
  logic              is_trap;
`endif

  pipe_cu_decode u_decode (
    .opcode (id_opcode),
    .ctrl   (dec_bits)
  );

  assign dec       = ctrl_t'(dec_bits);
  assign hazard    = load_use(id_valid, ex_memread, ex_rd, id_rs1, id_rs2);
  assign is_ebreak = id_valid && (id_opcode == OPCODE_SYSTEM) && id_inst20;
`ifdef PIPE_CU_TRAP_EN
  assign is_trap   = id_valid && (((id_opcode == OPCODE_SYSTEM) && !id_inst20) || (id_opcode == OPCODE_FENCE));
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ex_next    = '0;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    case (state_reg)
      ST_RUN: begin
        if (redirect) begin
          ifid_flush = 1'b1;
          state_next = FLUSH_ENTRY;
          cnt_next   = FLUSH_CNT;
        end else if (hazard) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          state_next = STALL_ENTRY;
          cnt_next   = STALL_CNT;
        end else if (is_ebreak) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          state_next = ST_HALT;
        end
`ifdef PIPE_CU_TRAP_EN
        else if (is_trap) begin
          ex_next.jump  = 1'b1;
          ex_next.pcsrc = PCSRC_TRAP;
          state_next    = ST_TRAP;
        end
`endif
        else if (id_valid) begin
          ex_next = dec;
        end
      end
      ST_STALL: begin
        if (redirect) begin
          ifid_flush = 1'b1;
          state_next = FLUSH_ENTRY;
          cnt_next   = FLUSH_CNT;
        end else begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          if (cnt_reg <= 2'd1) begin
            state_next = ST_RUN;
            cnt_next   = 2'd0;
          end else begin
            cnt_next = cnt_reg - 2'd1;
          end
        end
      end
      ST_FLUSH: begin
        ifid_flush = 1'b1;
        if (redirect) begin
          state_next = FLUSH_ENTRY;
          cnt_next   = FLUSH_CNT;
        end else if (cnt_reg <= 2'd1) begin
          state_next = ST_RUN;
          cnt_next   = 2'd0;
        end else begin
          cnt_next = cnt_reg - 2'd1;
        end
      end
      ST_HALT: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
      end
`ifdef PIPE_CU_TRAP_EN
      ST_TRAP: begin
        ifid_flush = 1'b1;
        state_next = FLUSH_ENTRY;
        cnt_next   = FLUSH_CNT;
      end
`endif
      default: begin
        state_next = ST_RUN;
        cnt_next   = 2'd0;
      end
    endcase
    // Enables must read as "free running" while reset is held, whatever the inputs say.
    if (!rst) begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_RUN;
      cnt_reg   <= 2'd0;
      ex_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ex_reg    <= ex_next;
    end
  end

  assign ex_branch    = ex_reg.branch;
  assign ex_memread_o = ex_reg.memread;
  assign ex_memtoreg  = ex_reg.memtoreg;
  assign ex_memwrite  = ex_reg.memwrite;
  assign ex_alusrc    = ex_reg.alusrc;
  assign ex_regwrite  = ex_reg.regwrite;
  assign ex_jump      = ex_reg.jump;
  assign ex_aluop     = ALUOP_W'(ex_reg.aluop);
  assign ex_regwsrc   = ex_reg.regwsrc;
  assign ex_pcsrc     = ex_reg.pcsrc;
  assign halted       = (state_reg == ST_HALT);
`ifdef PIPE_CU_TRAP_EN
  assign trap_req     = (state_reg == ST_TRAP);
`else
  assign trap_req     = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_control_unit.sv
// Randomized bench for pipe_control_unit against a cycle-budget reference model.
// Honours PIPE_CU_TRAP_EN the same way as the design.
module tb_pipe_control_unit;

  localparam int ALUOP_W     = 4;
  localparam int LOAD_STALL  = 2;
  localparam int FLUSH_DEPTH = 2;
  localparam logic [4:0] OP_SYS   = 5'b11100;
  localparam logic [4:0] OP_FENCE = 5'b00011;
  localparam logic [4:0] OP_R     = 5'b01100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic id_valid = 1'b0, id_inst20 = 1'b0, ex_memread = 1'b0, redirect = 1'b0;
  logic [4:0] id_opcode = '0, id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic pc_write, ifid_write, ifid_flush;
  logic ex_branch, ex_memread_o, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite, ex_jump;
  logic [ALUOP_W-1:0] ex_aluop;
  logic [1:0] ex_regwsrc, ex_pcsrc;
  logic halted, trap_req;
  logic [14:0] dut_ctrl;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: cycles of flush / stall still owed, plus halt and trap flags.
  int m_stall = 0, m_flush = 0;
  bit m_halted = 1'b0, m_trap = 1'b0;
  logic [14:0] exp_ctrl = '0;
  logic exp_halted = 1'b0, exp_trap = 1'b0;

  pipe_control_unit #(
    .ALUOP_W(ALUOP_W), .LOAD_STALL(LOAD_STALL), .FLUSH_DEPTH(FLUSH_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_inst20(id_inst20),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread), .redirect(redirect),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .ex_branch(ex_branch), .ex_memread_o(ex_memread_o), .ex_memtoreg(ex_memtoreg),
    .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc), .ex_regwrite(ex_regwrite), .ex_jump(ex_jump),
    .ex_aluop(ex_aluop), .ex_regwsrc(ex_regwsrc), .ex_pcsrc(ex_pcsrc),
    .halted(halted), .trap_req(trap_req)
  );

  always #5 clk = ~clk;

  assign dut_ctrl = {ex_branch, ex_memread_o, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite,
                     ex_jump, ex_aluop, ex_regwsrc, ex_pcsrc};

  // Bundle layout: {branch,memread,memtoreg,memwrite,alusrc,regwrite,jump, aluop[3:0], regwsrc, pcsrc}
  function automatic logic [14:0] ref_ctrl(input logic [4:0] op);
    logic [14:0] r;
    r = '0;
    case (op)
      5'b01100: r = {7'b0000010, 4'd2, 2'b00, 2'b00};
      5'b00000: r = {7'b0110110, 4'd0, 2'b00, 2'b00};
      5'b01000: r = {7'b0001100, 4'd0, 2'b00, 2'b00};
      5'b11000: r = {7'b1000000, 4'd1, 2'b00, 2'b01};
      5'b00100: r = {7'b0000110, 4'd3, 2'b00, 2'b00};
      5'b01101: r = {7'b0000110, 4'd4, 2'b00, 2'b00};
      5'b00101: r = {7'b0000110, 4'd4, 2'b10, 2'b00};
      5'b11001: r = {7'b0000111, 4'd5, 2'b01, 2'b10};
      5'b11011: r = {7'b0000011, 4'd5, 2'b01, 2'b01};
      default:  r = '0;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_regs();
    chk("ex_ctrl", 32'(dut_ctrl), 32'(exp_ctrl));
    chk("halted", 32'(halted), 32'(exp_halted));
    chk("trap_req", 32'(trap_req), 32'(exp_trap));
  endtask

  task automatic do_reset(input bit pre);
    @(negedge clk);
    if (pre) check_regs();
    #2 rst = 1'b0;
    #1;
    chk("rst_ctrl", 32'(dut_ctrl), 32'd0);
    chk("rst_pc_write", 32'(pc_write), 32'd1);
    chk("rst_ifid_write", 32'(ifid_write), 32'd1);
    chk("rst_ifid_flush", 32'(ifid_flush), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_trap_req", 32'(trap_req), 32'd0);
    m_stall = 0; m_flush = 0; m_halted = 1'b0; m_trap = 1'b0;
    exp_ctrl = '0; exp_halted = 1'b0; exp_trap = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    $display("cyc %0d reset", cyc);
  endtask

  task automatic cycle(input logic v, input logic [4:0] op, input logic i20, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] rd, input logic mr, input logic rdr);
    logic haz, e_pc, e_ifw, e_fl;
    logic [14:0] nb;
    @(negedge clk);
    check_regs();
    id_valid = v; id_opcode = op; id_inst20 = i20; id_rs1 = r1; id_rs2 = r2;
    ex_rd = rd; ex_memread = mr; redirect = rdr;
    #1;
    haz = v && mr && (rd != 5'd0) && ((rd == r1) || (rd == r2));
    e_pc = 1'b1; e_ifw = 1'b1; e_fl = 1'b0; nb = '0;
    if (m_halted) begin
      e_pc = 1'b0; e_ifw = 1'b0;
    end else if (m_trap || rdr) begin
      e_fl = 1'b1; m_trap = 1'b0; m_flush = FLUSH_DEPTH - 1; m_stall = 0;
    end else if (m_flush > 0) begin
      e_fl = 1'b1; m_flush--;
    end else if (m_stall > 0) begin
      e_pc = 1'b0; e_ifw = 1'b0; m_stall--;
    end else if (haz) begin
      e_pc = 1'b0; e_ifw = 1'b0; m_stall = LOAD_STALL - 1;
    end else if (v && op == OP_SYS && i20) begin
      e_pc = 1'b0; e_ifw = 1'b0; m_halted = 1'b1;
    end
`ifdef PIPE_CU_TRAP_EN
    else if (v && ((op == OP_SYS && !i20) || op == OP_FENCE)) begin
      nb = {7'b0000001, 4'd0, 2'b00, 2'b11}; m_trap = 1'b1;
    end
`endif
    else if (v) begin
      nb = ref_ctrl(op);
    end
    chk("pc_write", 32'(pc_write), 32'(e_pc));
    chk("ifid_write", 32'(ifid_write), 32'(e_ifw));
    chk("ifid_flush", 32'(ifid_flush), 32'(e_fl));
    exp_ctrl = nb; exp_halted = m_halted; exp_trap = m_trap;
    $display("cyc %0d v=%0d op=%b i20=%0d haz=%0d rdr=%0d pcw=%0d flush=%0d ctrl_next=%h",
             cyc, v, op, i20, haz, rdr, pc_write, ifid_flush, nb);
    cyc++;
  endtask

  initial begin
    int halt_cnt;
    logic [4:0] ops [12];
    ops = '{5'b00000, 5'b01000, 5'b11000, 5'b00100, 5'b01100, 5'b01101,
            5'b00101, 5'b11001, 5'b11011, 5'b11100, 5'b00011, 5'b10101};
    do_reset(1'b0);
    // R-type, then load-use hazard on rs2, then ex_rd=0 (no stall)
    cycle(1, OP_R, 0, 1, 2, 0, 0, 0);
    cycle(1, OP_R, 0, 1, 5, 5, 1, 0);
    cycle(1, OP_R, 0, 1, 5, 0, 0, 0);
    cycle(1, OP_R, 0, 1, 5, 0, 0, 0);
    cycle(1, OP_R, 0, 0, 0, 0, 1, 0);
    // redirect alone, then redirect with a concurrent hazard
    cycle(1, 5'b00000, 0, 3, 4, 7, 0, 1);
    cycle(1, OP_R, 0, 3, 4, 0, 0, 0);
    cycle(1, OP_R, 0, 3, 4, 0, 0, 0);
    cycle(1, OP_R, 0, 5, 0, 5, 1, 1);
    cycle(1, OP_R, 0, 5, 0, 0, 0, 0);
    cycle(1, OP_R, 0, 5, 0, 0, 0, 0);
    // reset in the middle of a stall must leave no residual bubble
    cycle(1, OP_R, 0, 5, 0, 5, 1, 0);
    do_reset(1'b1);
    cycle(1, OP_R, 0, 1, 2, 0, 0, 0);
    // ECALL / FENCE, then EBREAK halt held 100 cycles with redirects
    cycle(1, OP_SYS, 0, 0, 0, 0, 0, 0);
    cycle(1, OP_R, 0, 0, 0, 0, 0, 0);
    cycle(1, OP_FENCE, 0, 0, 0, 0, 0, 0);
    cycle(1, OP_R, 0, 0, 0, 0, 0, 0);
    cycle(1, OP_R, 0, 0, 0, 0, 0, 0);
    cycle(0, OP_SYS, 1, 0, 0, 0, 0, 0);
    cycle(1, OP_SYS, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++)
      cycle(1, OP_R, 0, 1, 1, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    do_reset(1'b1);
    // randomized traffic
    halt_cnt = 0;
    for (int n = 0; n < 1500; n++) begin
      if (halt_cnt > 8 || $urandom_range(0, 199) == 0) begin
        do_reset(1'b1);
        halt_cnt = 0;
      end
      cycle(1'($urandom_range(0, 5) != 0), ops[$urandom_range(0, 11)],
            1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0));
      if (m_halted) halt_cnt++;
    end
    @(negedge clk);
    check_regs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
